// File: rtl/apu_pkg.sv
`default_nettype none
// ==========================================================================
// Package : apu_pkg
// Brief   : Register offsets, channel config structs and frame-step masks.
// Rev     : 1.0  initial release
// ==========================================================================
package apu_pkg;

   localparam logic [4:0] NR10 = 5'h00;
   localparam logic [4:0] NR11 = 5'h01;
   localparam logic [4:0] NR12 = 5'h02;
   localparam logic [4:0] NR13 = 5'h03;
   localparam logic [4:0] NR14 = 5'h04;
   localparam logic [4:0] NR21 = 5'h06;
   localparam logic [4:0] NR22 = 5'h07;
   localparam logic [4:0] NR23 = 5'h08;
   localparam logic [4:0] NR24 = 5'h09;
   localparam logic [4:0] NR30 = 5'h0A;
   localparam logic [4:0] NR31 = 5'h0B;
   localparam logic [4:0] NR32 = 5'h0C;
   localparam logic [4:0] NR33 = 5'h0D;
   localparam logic [4:0] NR34 = 5'h0E;
   localparam logic [4:0] NR41 = 5'h10;
   localparam logic [4:0] NR42 = 5'h11;
   localparam logic [4:0] NR43 = 5'h12;
   localparam logic [4:0] NR44 = 5'h13;
   localparam logic [4:0] NR50 = 5'h14;
   localparam logic [4:0] NR51 = 5'h15;
   localparam logic [4:0] NR52 = 5'h16;

   // Bit n set means the strobe fires on entry to frame step n.
   localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
   localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
   localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

   typedef struct packed {
      logic [2:0]  swp_pd;
      logic        negate;
      logic [2:0]  shift;
      logic [1:0]  duty;
      logic [5:0]  len_load;
      logic [3:0]  start_vol;
      logic        env_add;
      logic [2:0]  period;
      logic [10:0] freq;
      logic        len_enable;
   } sq1_cfg_t;

   typedef struct packed {
      logic [1:0]  duty;
      logic [5:0]  len_load;
      logic [3:0]  start_vol;
      logic        env_add;
      logic [2:0]  period;
      logic [10:0] freq;
      logic        len_enable;
   } sq2_cfg_t;

   typedef struct packed {
      logic        dac_en;
      logic [1:0]  vol;
      logic [7:0]  len_load;
      logic [10:0] freq;
      logic        len_enable;
   } w_cfg_t;

   typedef struct packed {
      logic [5:0]  len_load;
      logic [3:0]  start_vol;
      logic        env_add;
      logic [2:0]  period;
      logic [3:0]  clk_shift;
      logic        width_mode;
      logic [2:0]  divisor;
      logic        len_enable;
   } n_cfg_t;

   typedef struct packed {
      logic [7:0]  nr50;
      logic [7:0]  nr51;
   } mix_cfg_t;

endpackage
`default_nettype wire

// File: rtl/apu_reg_controller_if.sv
`default_nettype none
// ==========================================================================
// Interface : apu_reg_controller_if
// Brief     : Byte-wide valid/ready register write port.
// Rev       : 1.0  initial release
// ==========================================================================
interface apu_reg_controller_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// ==========================================================================
// Module : apu_frame_sequencer
// Brief  : 512 Hz step divider producing length, sweep and envelope strobes.
// Rev    : 1.0  initial release
// ==========================================================================
module apu_frame_sequencer
   import apu_pkg::*;
#(
   parameter int DIV_512 = 8192
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic enable,
   output logic len_tick,
   output logic sweep_tick,
   output logic env_tick
);

   localparam int                 c_div_w    = (DIV_512 > 1) ? $clog2(DIV_512) : 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV_512 - 1);

   logic [c_div_w-1:0] r_div;
   logic [2:0]         r_step;
   logic [2:0]         w_next_step;

   assign w_next_step = r_step + 3'd1;

   // Step parks at 7 so the first wrap enters step 0 and fires len_tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div      <= '0;
         r_step     <= 3'd7;
         len_tick   <= 1'b0;
         sweep_tick <= 1'b0;
         env_tick   <= 1'b0;
      end else if (restart || !enable) begin
         r_div      <= '0;
         r_step     <= 3'd7;
         len_tick   <= 1'b0;
         sweep_tick <= 1'b0;
         env_tick   <= 1'b0;
      end else if (r_div == c_div_last) begin
         r_div      <= '0;
         r_step     <= w_next_step;
         len_tick   <= LEN_STEPS[w_next_step];
         sweep_tick <= SWEEP_STEPS[w_next_step];
         env_tick   <= ENV_STEPS[w_next_step];
      end else begin
         r_div      <= r_div + 1'b1;
         len_tick   <= 1'b0;
         sweep_tick <= 1'b0;
         env_tick   <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/apu_reg_controller.sv
`default_nettype none
// ==========================================================================
// Module : apu_reg_controller
// Brief  : NR10-NR52 register file, channel config decode, trigger pulses.
// Rev    : 1.0  initial release
// ==========================================================================
module apu_reg_controller
   import apu_pkg::*;
#(
   parameter int DIV_512     = 8192,
   parameter int TRIG_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   apu_reg_controller_if.slave  wr,
   output sq1_cfg_t             sq1_cfg,
   output sq2_cfg_t             sq2_cfg,
   output w_cfg_t               w_cfg,
   output n_cfg_t               n_cfg,
   output mix_cfg_t             mix_cfg,
   output logic [3:0]           trigger,
   output logic                 len_tick,
   output logic                 sweep_tick,
   output logic                 env_tick,
   output logic                 master_en
);

   localparam logic [3:0] c_trig_len = 4'(TRIG_CYCLES);

   sq1_cfg_t   r_sq1;
   sq2_cfg_t   r_sq2;
   w_cfg_t     r_wave;
   n_cfg_t     r_noise;
   mix_cfg_t   r_mix;
   logic       r_master_en;

   logic       w_accept;
   logic       w_is_nr52;
   logic       w_power_on;
   logic       w_power_off;
   logic       w_wr_en;
   logic [3:0] w_trig_req;

   // Holding off writes during a pulse guarantees triggers never overlap.
   assign wr.wr_ready  = ~|trigger;
   assign w_accept     = wr.wr_valid & wr.wr_ready;
   assign w_is_nr52    = (wr.wr_addr == NR52);
   assign w_power_on   = w_accept & w_is_nr52 &  wr.wr_data[7] & ~r_master_en;
   assign w_power_off  = w_accept & w_is_nr52 & ~wr.wr_data[7] &  r_master_en;
   assign w_wr_en      = w_accept & r_master_en & ~w_is_nr52;

   assign w_trig_req[0] = w_wr_en & (wr.wr_addr == NR14) & wr.wr_data[7];
   assign w_trig_req[1] = w_wr_en & (wr.wr_addr == NR24) & wr.wr_data[7];
   assign w_trig_req[2] = w_wr_en & (wr.wr_addr == NR34) & wr.wr_data[7] & r_wave.dac_en;
   assign w_trig_req[3] = w_wr_en & (wr.wr_addr == NR44) & wr.wr_data[7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sq1       <= '0;
         r_sq2       <= '0;
         r_wave      <= '0;
         r_noise     <= '0;
         r_mix       <= '0;
         r_master_en <= 1'b1;
      end else if (w_power_off) begin
         r_sq1       <= '0;
         r_sq2       <= '0;
         r_wave      <= '0;
         r_noise     <= '0;
         r_mix       <= '0;
         r_master_en <= 1'b0;
      end else if (w_power_on) begin
         r_master_en <= 1'b1;
      end else if (w_wr_en) begin
         case (wr.wr_addr)
            NR10: {r_sq1.swp_pd, r_sq1.negate, r_sq1.shift}        <= wr.wr_data[6:0];
            NR11: {r_sq1.duty, r_sq1.len_load}                     <= wr.wr_data;
            NR12: {r_sq1.start_vol, r_sq1.env_add, r_sq1.period}   <= wr.wr_data;
            NR13: r_sq1.freq[7:0]                                  <= wr.wr_data;
            NR14: {r_sq1.len_enable, r_sq1.freq[10:8]}             <= {wr.wr_data[6], wr.wr_data[2:0]};
            NR21: {r_sq2.duty, r_sq2.len_load}                     <= wr.wr_data;
            NR22: {r_sq2.start_vol, r_sq2.env_add, r_sq2.period}   <= wr.wr_data;
            NR23: r_sq2.freq[7:0]                                  <= wr.wr_data;
            NR24: {r_sq2.len_enable, r_sq2.freq[10:8]}             <= {wr.wr_data[6], wr.wr_data[2:0]};
            NR30: r_wave.dac_en                                    <= wr.wr_data[7];
            NR31: r_wave.len_load                                  <= wr.wr_data;
            NR32: r_wave.vol                                       <= wr.wr_data[6:5];
            NR33: r_wave.freq[7:0]                                 <= wr.wr_data;
            NR34: {r_wave.len_enable, r_wave.freq[10:8]}           <= {wr.wr_data[6], wr.wr_data[2:0]};
            NR41: r_noise.len_load                                 <= wr.wr_data[5:0];
            NR42: {r_noise.start_vol, r_noise.env_add, r_noise.period} <= wr.wr_data;
            NR43: {r_noise.clk_shift, r_noise.width_mode, r_noise.divisor} <= wr.wr_data;
            NR44: r_noise.len_enable                               <= wr.wr_data[6];
            NR50: r_mix.nr50                                       <= wr.wr_data;
            NR51: r_mix.nr51                                       <= wr.wr_data;
            default: ;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_trig
         logic [3:0] r_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= 4'd0;
            end else if (w_power_off) begin
               r_cnt <= 4'd0;
            end else if (w_trig_req[gi]) begin
               r_cnt <= c_trig_len;
            end else if (r_cnt != 4'd0) begin
               r_cnt <= r_cnt - 4'd1;
            end
         end

         assign trigger[gi] = (r_cnt != 4'd0);
      end
   endgenerate

   apu_frame_sequencer #(
      .DIV_512 (DIV_512)
   ) u_frame_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .restart    (w_power_on | w_power_off),
      .enable     (r_master_en),
      .len_tick   (len_tick),
      .sweep_tick (sweep_tick),
      .env_tick   (env_tick)
   );

   assign sq1_cfg   = r_sq1;
   assign sq2_cfg   = r_sq2;
   assign w_cfg     = r_wave;
   assign n_cfg     = r_noise;
   assign mix_cfg   = r_mix;
   assign master_en = r_master_en;

endmodule
`default_nettype wire

// File: tb/tb_apu_reg_controller.sv
`default_nettype none
// ==========================================================================
// Module : tb_apu_reg_controller
// Brief  : Random writes against a byte-level behavioural model of the APU front-end.
// Rev    : 1.0  initial release
// ==========================================================================
module tb_apu_reg_controller;
   import apu_pkg::*;

   localparam int DIV  = 8;
   localparam int TRIG = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [34:0] sq1_cfg;
   logic [27:0] sq2_cfg;
   logic [22:0] w_cfg;
   logic [22:0] n_cfg;
   logic [15:0] mix_cfg;
   logic [3:0]  trigger;
   logic        len_tick, sweep_tick, env_tick, master_en;

   apu_reg_controller_if wr ();

   apu_reg_controller #(.DIV_512(DIV), .TRIG_CYCLES(TRIG)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr         (wr),
      .sq1_cfg    (sq1_cfg),
      .sq2_cfg    (sq2_cfg),
      .w_cfg      (w_cfg),
      .n_cfg      (n_cfg),
      .mix_cfg    (mix_cfg),
      .trigger    (trigger),
      .len_tick   (len_tick),
      .sweep_tick (sweep_tick),
      .env_tick   (env_tick),
      .master_en  (master_en)
   );

   always #5 clk = ~clk;

   // Model: raw register bytes, power flag, remaining pulse cycles, cycles since divider restart.
   logic [7:0] m_reg [0:31];
   logic       m_on;
   int         m_trig [4];
   int         m_t;
   int         cyc;
   int         n_vec = 0;
   int         n_err = 0;

   logic        mdl_ready, mdl_accept;
   logic [34:0] e_sq1;
   logic [27:0] e_sq2;
   logic [22:0] e_w, e_n;
   logic [15:0] e_mix;
   logic        e_len, e_sweep, e_env;
   int          e_step;

   function automatic int trig_chan(input logic [4:0] a);
      case (a)
         5'h04:   return 0;
         5'h09:   return 1;
         5'h0E:   return 2;
         5'h13:   return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic mapped(input logic [4:0] a);
      return (a <= 5'h15) && (a != 5'h05) && (a != 5'h0F);
   endfunction

   always_comb begin
      mdl_ready  = (m_trig[0] == 0) && (m_trig[1] == 0) && (m_trig[2] == 0) && (m_trig[3] == 0);
      mdl_accept = wr.wr_valid && mdl_ready;
      e_sq1 = {m_reg[0][6:0], m_reg[1], m_reg[2], m_reg[4][2:0], m_reg[3], m_reg[4][6]};
      e_sq2 = {m_reg[6], m_reg[7], m_reg[9][2:0], m_reg[8], m_reg[9][6]};
      e_w   = {m_reg[10][7], m_reg[12][6:5], m_reg[11], m_reg[14][2:0], m_reg[13], m_reg[14][6]};
      e_n   = {m_reg[16][5:0], m_reg[17], m_reg[18], m_reg[19][6]};
      e_mix = {m_reg[20], m_reg[21]};
      e_len = 1'b0; e_sweep = 1'b0; e_env = 1'b0; e_step = 0;
      if (m_t > 0 && (m_t % DIV) == 0) begin
         e_step  = (m_t / DIV - 1) % 8;
         e_len   = (e_step % 2) == 0;
         e_sweep = (e_step == 2) || (e_step == 6);
         e_env   = (e_step == 7);
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_reg[i] <= 8'h00;
         for (int i = 0; i < 4; i++) m_trig[i] <= 0;
         m_on <= 1'b1;
         m_t  <= 0;
         cyc  <= 0;
      end else begin
         cyc <= cyc + 1;
         for (int i = 0; i < 4; i++) if (m_trig[i] > 0) m_trig[i] <= m_trig[i] - 1;
         if (m_on) m_t <= m_t + 1;
         if (mdl_accept) begin
            if (wr.wr_addr == 5'h16) begin
               if (wr.wr_data[7] && !m_on) begin
                  m_on <= 1'b1;
                  m_t  <= 0;
               end else if (!wr.wr_data[7] && m_on) begin
                  m_on <= 1'b0;
                  m_t  <= 0;
                  for (int i = 0; i < 32; i++) m_reg[i] <= 8'h00;
                  for (int i = 0; i < 4; i++) m_trig[i] <= 0;
               end
            end else if (m_on && mapped(wr.wr_addr)) begin
               m_reg[wr.wr_addr] <= wr.wr_data;
               if (trig_chan(wr.wr_addr) >= 0 && wr.wr_data[7] &&
                   (trig_chan(wr.wr_addr) != 2 || m_reg[10][7]))
                  m_trig[trig_chan(wr.wr_addr)] <= TRIG;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wr_byte(input logic [4:0] a, input logic [7:0] d, output int acc);
      int k;
      @(negedge clk);
      wr.wr_valid = 1'b1;
      wr.wr_addr  = a;
      wr.wr_data  = d;
      k = 0;
      while (!wr.wr_ready && k < 64) begin
         @(negedge clk);
         k++;
      end
      if (k >= 64) begin
         n_err++;
         $display("FAIL wr_timeout: ready never rose for addr %0h", a);
         wr.wr_valid = 1'b0;
         acc = -1;
      end else begin
         @(negedge clk);
         wr.wr_valid = 1'b0;
         acc = cyc;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int acc, acc2, hi, hits, tcyc, f_len, f_sweep, f_env, r;
   logic [4:0] a;
   logic [7:0] d;
   logic [4:0] trig_addr [4] = '{5'h04, 5'h09, 5'h0E, 5'h13};

   initial begin
      rst_n       = 1'b0;
      wr.wr_valid = 1'b0;
      wr.wr_addr  = 5'h00;
      wr.wr_data  = 8'h00;

      fork
         forever begin
            @(negedge clk);
            chk("wr_ready",   64'(wr.wr_ready), 64'(mdl_ready));
            chk("trigger",    64'(trigger), 64'({m_trig[3] > 0, m_trig[2] > 0, m_trig[1] > 0, m_trig[0] > 0}));
            chk("len_tick",   64'(len_tick), 64'(e_len));
            chk("sweep_tick", 64'(sweep_tick), 64'(e_sweep));
            chk("env_tick",   64'(env_tick), 64'(e_env));
            chk("master_en",  64'(master_en), 64'(m_on));
            chk("sq1_cfg",    64'(sq1_cfg), 64'(e_sq1));
            chk("sq2_cfg",    64'(sq2_cfg), 64'(e_sq2));
            chk("w_cfg",      64'(w_cfg), 64'(e_w));
            chk("n_cfg",      64'(n_cfg), 64'(e_n));
            chk("mix_cfg",    64'(mix_cfg), 64'(e_mix));
         end
      join_none

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_sq1", 64'(sq1_cfg), 64'd0);
      chk("rst_ready", 64'(wr.wr_ready), 64'd1);
      chk("rst_master_en", 64'(master_en), 64'd1);

      // Frame strobe timing straight out of reset
      f_len = -1; f_sweep = -1; f_env = -1;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (len_tick && f_len < 0)     f_len = cyc;
         if (sweep_tick && f_sweep < 0) f_sweep = cyc;
         if (env_tick && f_env < 0)     f_env = cyc;
      end
      chk("first_len_tick", 64'(f_len), 64'd8);
      chk("first_sweep_tick", 64'(f_sweep), 64'd24);
      chk("first_env_tick", 64'(f_env), 64'd64);

      // NR12 / NR14 trigger
      wr_byte(5'h02, 8'hF3, acc);
      wr_byte(5'h04, 8'hC5, acc);
      chk("sq1_literal", 64'(sq1_cfg), 64'h0F3A01);
      chk("trig0_rise", 64'(trigger[0]), 64'd1);
      hi = 0;
      for (int k = 0; k < 10; k++) begin
         if (trigger[0]) hi++;
         @(negedge clk);
      end
      chk("trig0_width", 64'(hi), 64'd4);

      // Wave trigger suppressed by dacEn=0, then allowed
      wr_byte(5'h0A, 8'h00, acc);
      wr_byte(5'h0E, 8'h80, acc);
      chk("wave_suppressed", 64'(trigger[2]), 64'd0);
      chk("wave_supp_ready", 64'(wr.wr_ready), 64'd1);
      wr_byte(5'h0A, 8'h80, acc);
      wr_byte(5'h0E, 8'h80, acc);
      hi = 0;
      for (int k = 0; k < 10; k++) begin
         if (trigger[2]) hi++;
         @(negedge clk);
      end
      chk("trig2_width", 64'(hi), 64'd4);

      // Load everything, power off, write while off, power on
      for (int i = 0; i < 22; i++) wr_byte(5'(i), 8'($urandom), acc);
      wr_byte(5'h16, 8'h00, acc);
      chk("off_cfg_all", 64'({sq1_cfg, sq2_cfg}), 64'd0);
      chk("off_cfg_rest", 64'({w_cfg, n_cfg, mix_cfg}), 64'd0);
      chk("off_master_en", 64'(master_en), 64'd0);
      wr_byte(5'h07, 8'hFF, acc);
      chk("off_write_dropped", 64'(sq2_cfg), 64'd0);
      hits = 0;
      for (int k = 0; k < 3 * DIV; k++) begin
         @(negedge clk);
         if (len_tick || sweep_tick || env_tick) hits++;
      end
      chk("off_no_ticks", 64'(hits), 64'd0);
      wr_byte(5'h16, 8'h80, acc);
      tcyc = -1000;
      for (int k = 0; k < 4 * DIV; k++) begin
         @(negedge clk);
         if (len_tick) begin tcyc = cyc; break; end
      end
      chk("poweron_len_delay", 64'(tcyc - acc), 64'(DIV));

      // Power-off queued behind a noise trigger
      wr_byte(5'h13, 8'h80, acc);
      wr_byte(5'h16, 8'h00, acc2);
      chk("off_after_pulse", 64'(acc2 - acc), 64'(TRIG + 1));
      chk("off_trig_low", 64'(trigger), 64'd0);
      hits = 0;
      for (int k = 0; k < 3 * DIV; k++) begin
         @(negedge clk);
         if (len_tick || sweep_tick || env_tick) hits++;
      end
      chk("off2_no_ticks", 64'(hits), 64'd0);
      wr_byte(5'h16, 8'h80, acc);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            a = 5'h16;
            d = {($urandom_range(0, 3) != 0), 7'($urandom)};
         end else if (r < 5) begin
            a = trig_addr[$urandom_range(0, 3)];
            d = 8'($urandom) | 8'h80;
         end else begin
            a = 5'($urandom);
            d = 8'($urandom);
         end
         wr_byte(a, d, acc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Async reset mid trigger pulse during step 5
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 100 && cyc < 45; k++) @(negedge clk);
      wr_byte(5'h04, 8'h87, acc);
      @(negedge clk);
      chk("pre_reset_pulse", 64'(trigger[0]), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_trig", 64'(trigger), 64'd0);
      chk("async_rst_sq1", 64'(sq1_cfg), 64'd0);
      chk("async_rst_ready", 64'(wr.wr_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      f_len = -1;
      for (int k = 0; k < 4 * DIV; k++) begin
         @(negedge clk);
         if (len_tick) begin f_len = cyc; break; end
      end
      chk("post_rst_len_tick", 64'(f_len), 64'(DIV));

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apu_reg_controller.md
Name: apu_reg_controller

Overview:
- Register front-end and sequencer for the sound channels: accepts byte writes to the NR10–NR52 register map (offset from 0xFF10) over a valid/ready port.
- Holds the register file and decodes it into per-channel configuration buses.
- Issues stretched trigger pulses to the channels.
- Runs the 512 Hz frame sequencer that produces the length, sweep and envelope strobes.
- Sits between the host/playback driver and the pulse1/pulse2/wave/noise channels and the mixer.

Parameters:
- DIV_512, 8192: clk cycles per frame-sequencer step (4.194304 MHz / 512).
- TRIG_CYCLES, 4: width of each trigger pulse in clk cycles, range 1–15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous and active-low.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  5  register offset 0x00–0x16.
- wr_data  in  8  write data.
- sq1_cfg  out  35  {swpPd3, negate1, shift3, duty2, lenLoad6, startVol4, envAdd1, period3, freq11, lenEnable1}.
- sq2_cfg  out  28  {duty2, lenLoad6, startVol4, envAdd1, period3, freq11, lenEnable1}.
- w_cfg  out  23  {dacEn1, vol2, lenLoad8, freq11, lenEnable1}.
- n_cfg  out  23  {lenLoad6, startVol4, envAdd1, period3, clkShift4, widthMode1, divisor3, lenEnable1}.
- mix_cfg  out  16  {NR50, NR51}.
- trigger  out  4  {noise, wave, sq2, sq1} trigger pulses.
- len_tick  out  1  256 Hz strobe.
- sweep_tick  out  1  128 Hz strobe.
- env_tick  out  1  64 Hz strobe.
- master_en  out  1  NR52 bit 7.

Behaviour:
- Reset (async, rst_n=0):
  - All registers 0, so all cfg buses = 0.
  - trigger=0, ticks=0, wr_ready=1, master_en=1.
  - Divider = 0, step = 7.
- Register write accept:
  - Fields latch on the accepting edge; cfg outputs are registered and valid the next cycle.
- Field map:
  - NR10 [6:4] swpPd, [3] negate, [2:0] shift.
  - NRx1 [7:6] duty, [5:0] lenLoad (NR31 is the full 8-bit lenLoad).
  - NRx2 [7:4] startVol, [3] envAdd, [2:0] period.
  - NRx3 freq[7:0]; NRx4 [7] trigger, [6] lenEnable, [2:0] freq[10:8].
  - NR30 [7] dacEn; NR32 [6:5] vol.
  - NR43 [7:4] clkShift, [3] widthMode, [2:0] divisor.
  - NR50/NR51 are stored whole.
- Unmapped offsets (0x05, 0x0F, >0x16):
  - Accepted and dropped, no side effect.
- Trigger:
  - A write to NR14/24/34/44 with bit 7 = 1 asserts the matching trigger bit from the next cycle for exactly TRIG_CYCLES cycles.
  - Freq and lenEnable from the same write are already visible on cfg when the trigger rises.
  - Bit 7 is not stored.
- Trigger handshake:
  - wr_ready = 0 while any trigger bit is high, so triggers never overlap.
  - wr_ready rises the cycle after the pulse ends.
- Trigger suppression:
  - NR30 dacEn=0 suppresses a wave trigger: the write is accepted and no pulse is issued.
- Frame sequencer:
  - The divider counts 0..DIV_512-1; on wrap, step = step+1 mod 8.
  - On the cycle the step is entered, single-cycle strobes fire:
    - len_tick at steps 0, 2, 4, 6.
    - sweep_tick at steps 2, 6.
    - env_tick at step 7.
- Power off (NR52 write with bit 7 = 0):
  - Next cycle: all NR10–NR51 state is cleared.
  - Active triggers are forced low and wr_ready returns to 1.
  - Divider = 0, step = 7, ticks are suppressed.
  - Writes to offsets other than 0x16 are accepted and dropped while master_en=0.
- Power on (NR52 bit 7 = 1 while off):
  - Divider restarts from 0 and step = 7.
  - The first strobe is len_tick (entering step 0) exactly DIV_512 cycles later.
  - Writing 1 while already on has no effect.
- Simultaneous events:
  - A frame tick coincident with a write is independent of it.
  - Power-off takes priority over a pending trigger.
  - Async reset mid-pulse clears the pulse immediately.

Decomposition:
- apu_pkg holds:
  - Register offset localparams (NR10..NR52).
  - Packed struct typedefs sq1_cfg_t, sq2_cfg_t, w_cfg_t, n_cfg_t, mix_cfg_t.
  - Frame-step tick masks LEN_STEPS=8'b01010101, SWEEP_STEPS=8'b01000100, ENV_STEPS=8'b10000000.
- Sub-module apu_frame_sequencer:
  - Contains the divider, step counter and strobes.
  - Inputs: clk, rst_n, restart, enable.
- Trigger stretchers are four instances of one counter generated inline.

Test Plan:
- Write NR12=0xF3, then NR14=0xC5 -> sq1_cfg startVol=0xF, envAdd=0, period=3, lenEnable=1, freq[10:8]=5; trigger[0] high 4 cycles starting 1 cycle after accept; wr_ready low those 4 cycles.
- Reset with DIV_512=8 -> len_tick at cycle 8; sweep_tick+len_tick at cycle 24; env_tick at cycle 64; pattern repeats every 64 cycles.
- NR30=0x00, then NR34=0x80 -> no trigger[2] pulse, wr_ready stays 1. NR30=0x80, then NR34=0x80 -> 4-cycle pulse.
- Load all registers, then NR52=0x00 -> all cfg=0 next cycle; write NR22=0xFF ignored; NR52=0x80 -> first len_tick DIV_512 cycles later.
- NR44=0x80, then NR52=0x00 one cycle later (held off by ready) -> controller stalls until pulse ends; with DIV_512=8, issue power-off via a queued write after the pulse and check ticks stop.
- Assert rst_n low mid trigger pulse and mid step 5 -> trigger=0, cfg=0, step restarts at 7 asynchronously; first len_tick DIV_512 cycles after release.
